inst_tx_sched: RTL and testbench

Parametrised successor of the single-slot instruction transmit controller. It buffers incoming instructions in a FIFO of depth QDEPTH instead of dropping them. Each instruction is replayed a configured number of times with a configured gap, routed to one of CH_NUM keyer channels, and logged with a timestamp. The block sits between the instruction memory reader and the per-keyer encoders (PCM, DY, future keyers).

---
 rtl/inst_tx_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_inst_tx_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_tx_sched.sv
// Queued instruction transmit scheduler: FIFO-buffered, replayed txcnt times with a gap, routed to one keyer.
// Timestamped log path is built only when INST_TX_LOG_EN is defined; otherwise log outputs are tied low.
module inst_tx_sched #(
    parameter int DATA_W   = 512,
    parameter int TIME_W   = 64,
    parameter int QDEPTH   = 4,
    parameter int QADDR_W  = 2,
    parameter int CH_NUM   = 2,
    parameter int CH_SEL_W = 1
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic [15:0]               cfg_ins_txcnt,
    input  logic [31:0]               cfg_ins_waittime,
    input  logic [CH_SEL_W-1:0]       cfg_ch_sel,
    input  logic                      cfg_abort,
    input  logic [TIME_W-1:0]         local_time,
    input  logic [DATA_W-1:0]         inst_data,
    input  logic                      inst_data_valid,
    output logic                      inst_data_ready,
    output logic [DATA_W-1:0]         tx_inst_data,
    output logic [CH_NUM-1:0]         tx_inst_data_valid,
    output logic [TIME_W+DATA_W-1:0]  log_inst_data,
    output logic                      log_inst_data_valid,
    output logic                      busy,
    output logic [QADDR_W:0]          q_level,
    output logic                      debug_tx_overflow,
    output logic [15:0]               debug_drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    localparam logic [QADDR_W:0]  DEPTH_L  = (QADDR_W+1)'(QDEPTH);
    localparam logic [CH_SEL_W:0] CH_NUM_L = (CH_SEL_W+1)'(CH_NUM);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     mem_q [QDEPTH];
    logic [DATA_W-1:0]     mem_d [QDEPTH];
    logic [QADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [QADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [QADDR_W:0]      count_q, count_d;
    logic [DATA_W-1:0]     active_q, active_d;
    logic [15:0]           txcnt_q, txcnt_d;
    logic [31:0]           wait_q, wait_d;
    logic [CH_SEL_W-1:0]   sel_q, sel_d;
    logic [15:0]           sent_q, sent_d;
    logic [31:0]           wait_cnt_q, wait_cnt_d;
    logic [CH_NUM-1:0]     tx_valid_q, tx_valid_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic wr_en;
    logic drop;
    logic send_fire;

    assign fifo_full  = (count_q == DEPTH_L);
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == ST_LOAD);
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign wr_en      = inst_data_valid && (!fifo_full || pop) && !cfg_abort;
    assign drop       = inst_data_valid && fifo_full && !pop && !cfg_abort;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (cfg_abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = inst_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        txcnt_d    = txcnt_q;
        wait_d     = wait_q;
        sel_d      = sel_q;
        sent_d     = sent_q;
        wait_cnt_d = wait_cnt_q;
        send_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                active_d = mem_q[rd_ptr_q];
                txcnt_d  = cfg_ins_txcnt;
                wait_d   = cfg_ins_waittime;
                sel_d    = cfg_ch_sel;
                sent_d   = '0;
                if ((cfg_ins_txcnt == '0) || ({1'b0, cfg_ch_sel} >= CH_NUM_L)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                send_fire  = 1'b1;
                sent_d     = sent_q + 16'd1;
                wait_cnt_d = 32'd1;
                if (wait_q != '0) begin
                    state_d = ST_WAIT;
                end else if (sent_d < txcnt_q) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counts 1..wait_q so an all-ones gap never wraps.
                if (wait_cnt_q >= wait_q) begin
                    state_d = (sent_q < txcnt_q) ? ST_SEND : ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cfg_abort) begin
            state_d    = ST_IDLE;
            active_d   = active_q;
            sent_d     = '0;
            wait_cnt_d = '0;
        end
    end

    always_comb begin
        tx_valid_d = '0;
        if (send_fire && !cfg_abort) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                tx_valid_d[i] = (sel_q == CH_SEL_W'(i));
            end
        end
    end

    always_comb begin
        ovf_d      = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            active_q   <= '0;
            txcnt_q    <= '0;
            wait_q     <= '0;
            sel_q      <= '0;
            sent_q     <= '0;
            wait_cnt_q <= '0;
            tx_valid_q <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            active_q   <= active_d;
            txcnt_q    <= txcnt_d;
            wait_q     <= wait_d;
            sel_q      <= sel_d;
            sent_q     <= sent_d;
            wait_cnt_q <= wait_cnt_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef INST_TX_LOG_EN
    logic [TIME_W+DATA_W-1:0] log_data_q, log_data_d;
    logic                     log_valid_q, log_valid_d;

    always_comb begin
        log_valid_d = send_fire && !cfg_abort;
        log_data_d  = log_valid_d ? {local_time, active_q} : log_data_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            log_data_q  <= '0;
            log_valid_q <= 1'b0;
        end else begin
            log_data_q  <= log_data_d;
            log_valid_q <= log_valid_d;
        end
    end

    assign log_inst_data       = log_data_q;
    assign log_inst_data_valid = log_valid_q;
`else
    logic unused_local_time;
    assign unused_local_time   = ^local_time;
    assign log_inst_data       = '0;
    assign log_inst_data_valid = 1'b0;
`endif

    assign inst_data_ready    = !fifo_full;
    assign tx_inst_data       = active_q;
    assign tx_inst_data_valid = tx_valid_q;
    assign busy               = (state_q != ST_IDLE);
    assign q_level            = count_q;
    assign debug_tx_overflow  = ovf_q;
    assign debug_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_inst_tx_sched.sv
// Directed self-checking bench for inst_tx_sched: timing, backpressure, zero cases, bad channel, abort, reset.
module tb_inst_tx_sched;

    localparam int DATA_W   = 512;
    localparam int TIME_W   = 64;
    localparam int QDEPTH   = 4;
    localparam int QADDR_W  = 2;
    localparam int CH_NUM   = 2;
    localparam int CH_SEL_W = 2;

    logic                      clk_sys = 1'b0;
    logic                      rst_n   = 1'b0;
    logic [15:0]               cfg_ins_txcnt    = '0;
    logic [31:0]               cfg_ins_waittime = '0;
    logic [CH_SEL_W-1:0]       cfg_ch_sel       = '0;
    logic                      cfg_abort        = 1'b0;
    logic [TIME_W-1:0]         local_time;
    logic [DATA_W-1:0]         inst_data        = '0;
    logic                      inst_data_valid  = 1'b0;
    logic                      inst_data_ready;
    logic [DATA_W-1:0]         tx_inst_data;
    logic [CH_NUM-1:0]         tx_inst_data_valid;
    logic [TIME_W+DATA_W-1:0]  log_inst_data;
    logic                      log_inst_data_valid;
    logic                      busy;
    logic [QADDR_W:0]          q_level;
    logic                      debug_tx_overflow;
    logic [15:0]               debug_drop_cnt;

    inst_tx_sched #(
        .DATA_W   (DATA_W),
        .TIME_W   (TIME_W),
        .QDEPTH   (QDEPTH),
        .QADDR_W  (QADDR_W),
        .CH_NUM   (CH_NUM),
        .CH_SEL_W (CH_SEL_W)
    ) dut (
        .clk_sys             (clk_sys),
        .rst_n               (rst_n),
        .cfg_ins_txcnt       (cfg_ins_txcnt),
        .cfg_ins_waittime    (cfg_ins_waittime),
        .cfg_ch_sel          (cfg_ch_sel),
        .cfg_abort           (cfg_abort),
        .local_time          (local_time),
        .inst_data           (inst_data),
        .inst_data_valid     (inst_data_valid),
        .inst_data_ready     (inst_data_ready),
        .tx_inst_data        (tx_inst_data),
        .tx_inst_data_valid  (tx_inst_data_valid),
        .log_inst_data       (log_inst_data),
        .log_inst_data_valid (log_inst_data_valid),
        .busy                (busy),
        .q_level             (q_level),
        .debug_tx_overflow   (debug_tx_overflow),
        .debug_drop_cnt      (debug_drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;
    assign local_time = 64'(cyc);

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cyc  = 0;
    logic rdy [6];

    int                ev_cyc [$];
    logic [CH_NUM-1:0] ev_vec [$];
    logic [31:0]       ev_dat [$];
    int                lg_cyc [$];
    logic [31:0]       lg_time [$];
    logic [31:0]       lg_dat [$];
    int                ovf_seen  = 0;
    int                busy_fall = 0;
    logic              busy_prev = 1'b0;

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (tx_inst_data_valid != '0) begin
                ev_cyc.push_back(cyc);
                ev_vec.push_back(tx_inst_data_valid);
                ev_dat.push_back(tx_inst_data[31:0]);
            end
            if (log_inst_data_valid) begin
                lg_cyc.push_back(cyc);
                lg_time.push_back(log_inst_data[DATA_W +: 32]);
                lg_dat.push_back(log_inst_data[31:0]);
            end
            if (debug_tx_overflow) ovf_seen++;
            if (busy_prev && !busy) busy_fall = cyc;
        end
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_ev();
        ev_cyc.delete();
        ev_vec.delete();
        ev_dat.delete();
        lg_cyc.delete();
        lg_time.delete();
        lg_dat.delete();
        ovf_seen  = 0;
        busy_fall = 0;
    endtask

    task automatic write_one(input logic [31:0] d);
        @(negedge clk_sys);
        inst_data       = DATA_W'(d);
        inst_data_valid = 1'b1;
        @(negedge clk_sys);
        inst_data_valid = 1'b0;
        wr_cyc          = cyc;
    endtask

    task automatic write_burst(input int n, input logic [31:0] base);
        @(negedge clk_sys);
        for (int i = 0; i < n; i++) begin
            inst_data       = DATA_W'(base + 32'(i));
            inst_data_valid = 1'b1;
            rdy[i]          = inst_data_ready;
            @(negedge clk_sys);
        end
        inst_data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_sys);
            if (busy) seen = 1'b1;
            else if (seen && q_level == '0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 64'(done), 64'd1);
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_sys);
        check("rst_tx_valid", 64'(tx_inst_data_valid), 64'd0);
        check("rst_tx_data", tx_inst_data[63:0], 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_q_level", 64'(q_level), 64'd0);
        check("rst_log_valid", 64'(log_inst_data_valid), 64'd0);
        check("rst_drop_cnt", 64'(debug_drop_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // single instruction, three sends with 10-cycle gap on channel 1
        cfg_ins_txcnt = 16'd3; cfg_ins_waittime = 32'd10; cfg_ch_sel = 2'd1;
        clear_ev();
        write_one(32'hA1);
        wait_idle(200);
        check("t1_count", 64'(ev_cyc.size()), 64'd3);
        check("t1_vec", 64'(ev_vec[0]), 64'h2);
        check("t1_first_lat", 64'(ev_cyc[0] - wr_cyc), 64'd3);
        check("t1_gap01", 64'(ev_cyc[1] - ev_cyc[0]), 64'd11);
        check("t1_gap12", 64'(ev_cyc[2] - ev_cyc[1]), 64'd11);
        check("t1_data", 64'(ev_dat[2]), 64'hA1);
        check("t1_busy_fall", 64'(busy_fall - ev_cyc[2]), 64'd10);
`ifdef INST_TX_LOG_EN
        check("t1_log_count", 64'(lg_cyc.size()), 64'd3);
        check("t1_log_cyc", 64'(lg_cyc[0]), 64'(ev_cyc[0]));
        check("t1_log_time", 64'(lg_time[0]), 64'(ev_cyc[0] - 1));
        check("t1_log_data", 64'(lg_dat[1]), 64'hA1);
`else
        check("t1_log_count", 64'(lg_cyc.size()), 64'd0);
`endif

        // backpressure: six writes while the first instruction is in its gap
        cfg_ins_txcnt = 16'd1; cfg_ins_waittime = 32'd20; cfg_ch_sel = 2'd0;
        clear_ev();
        write_one(32'hB0);
        repeat (3) @(negedge clk_sys);
        write_burst(6, 32'hB1);
        check("t2_q_full", 64'(q_level), 64'd4);
        check("t2_rdy4", 64'(rdy[3]), 64'd1);
        check("t2_rdy5", 64'(rdy[4]), 64'd0);
        check("t2_rdy6", 64'(rdy[5]), 64'd0);
        wait_idle(400);
        check("t2_ovf_pulses", 64'(ovf_seen), 64'd2);
        check("t2_drop_cnt", 64'(debug_drop_cnt), 64'd2);
        check("t2_count", 64'(ev_cyc.size()), 64'd5);
        check("t2_order0", 64'(ev_dat[0]), 64'hB0);
        check("t2_order1", 64'(ev_dat[1]), 64'hB1);
        check("t2_order4", 64'(ev_dat[4]), 64'hB4);
        check("t2_vec", 64'(ev_vec[4]), 64'h1);
        check("t2_inst_gap", 64'(ev_cyc[1] - ev_cyc[0]), 64'd23);

        // txcnt = 0 discards the instruction
        cfg_ins_txcnt = 16'd0; cfg_ins_waittime = 32'd3; cfg_ch_sel = 2'd1;
        clear_ev();
        write_one(32'hC0);
        wait_idle(100);
        check("t3_count", 64'(ev_cyc.size()), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);

        // waittime = 0 gives back-to-back sends
        cfg_ins_txcnt = 16'd4; cfg_ins_waittime = 32'd0; cfg_ch_sel = 2'd1;
        clear_ev();
        write_one(32'hD0);
        wait_idle(100);
        check("t4_count", 64'(ev_cyc.size()), 64'd4);
        check("t4_gap01", 64'(ev_cyc[1] - ev_cyc[0]), 64'd1);
        check("t4_gap12", 64'(ev_cyc[2] - ev_cyc[1]), 64'd1);
        check("t4_gap23", 64'(ev_cyc[3] - ev_cyc[2]), 64'd1);
        check("t4_first_lat", 64'(ev_cyc[0] - wr_cyc), 64'd3);

        // channel 3 is out of range: first instruction dropped, second proceeds
        cfg_ins_txcnt = 16'd2; cfg_ins_waittime = 32'd0; cfg_ch_sel = 2'd3;
        clear_ev();
        write_burst(2, 32'hE0);
        @(negedge clk_sys);
        cfg_ch_sel = 2'd0;
        wait_idle(100);
        check("t5_count", 64'(ev_cyc.size()), 64'd2);
        check("t5_vec0", 64'(ev_vec[0]), 64'h1);
        check("t5_vec1", 64'(ev_vec[1]), 64'h1);
        check("t5_data", 64'(ev_dat[0]), 64'hE1);

        // abort during the gap with two instructions queued
        cfg_ins_txcnt = 16'd2; cfg_ins_waittime = 32'd20; cfg_ch_sel = 2'd0;
        clear_ev();
        write_one(32'hF0);
        repeat (3) @(negedge clk_sys);
        write_burst(2, 32'hF1);
        check("t6_q_before", 64'(q_level), 64'd2);
        cfg_abort = 1'b1;
        @(negedge clk_sys);
        cfg_abort = 1'b0;
        check("t6_q_after", 64'(q_level), 64'd0);
        check("t6_busy_after", 64'(busy), 64'd0);
        repeat (60) @(negedge clk_sys);
        check("t6_count", 64'(ev_cyc.size()), 64'd1);
        check("t6_busy_end", 64'(busy), 64'd0);

        // abort landing on the SEND cycle suppresses the pulse
        cfg_ins_txcnt = 16'd2; cfg_ins_waittime = 32'd0; cfg_ch_sel = 2'd1;
        clear_ev();
        write_one(32'h5A);
        repeat (2) @(negedge clk_sys);
        cfg_abort = 1'b1;
        @(negedge clk_sys);
        cfg_abort = 1'b0;
        check("t6b_no_pulse", 64'(tx_inst_data_valid), 64'd0);
        check("t6b_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk_sys);
        check("t6b_count", 64'(ev_cyc.size()), 64'd0);

        // asynchronous reset in the gap, then a clean instruction
        cfg_ins_txcnt = 16'd3; cfg_ins_waittime = 32'd30; cfg_ch_sel = 2'd0;
        clear_ev();
        write_one(32'h70);
        write_one(32'h71);
        repeat (3) @(negedge clk_sys);
        check("t7_q_before", 64'(q_level), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_q_level", 64'(q_level), 64'd0);
        check("t7_tx_valid", 64'(tx_inst_data_valid), 64'd0);
        check("t7_tx_data", tx_inst_data[63:0], 64'd0);
        check("t7_drop_cnt", 64'(debug_drop_cnt), 64'd0);
        check("t7_log_valid", 64'(log_inst_data_valid), 64'd0);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        cfg_ins_txcnt = 16'd1; cfg_ins_waittime = 32'd0; cfg_ch_sel = 2'd1;
        clear_ev();
        write_one(32'h72);
        wait_idle(100);
        check("t7_count", 64'(ev_cyc.size()), 64'd1);
        check("t7_vec", 64'(ev_vec[0]), 64'h2);
        check("t7_data", 64'(ev_dat[0]), 64'h72);
        check("t7_lat", 64'(ev_cyc[0] - wr_cyc), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
